// File: rtl/approx_rec_mult_seq_if.sv
// ----------------------------------------------------------------------------
// approx_rec_mult_seq_if
//
// Purpose:
//   Groups the operand-side and result-side handshakes of approx_rec_mult_seq.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   The source holds its payload stable while valid && !ready. ready may
//   depend on state only, never combinationally on valid.
//
// Signals:
//   in_valid  - producer has operands a/b/approx
//   in_ready  - multiplier can accept operands
//   a, b      - unsigned WIDTH-bit operands
//   approx    - 1 = approximate mode, 0 = exact; travels with a/b
//   out_valid - product y is valid
//   out_ready - consumer takes y
//   y         - unsigned 2*WIDTH-bit product
//
// Modports:
//   master - operand producer / result consumer side
//   slave  - the multiplier
// ----------------------------------------------------------------------------
interface approx_rec_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   approx;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     y;

    modport master (
        output in_valid, a, b, approx, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, approx, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/approx_rec_mult_seq.sv
// ----------------------------------------------------------------------------
// approx_rec_mult_seq
//
// Purpose:
//   Iterative unsigned WIDTH x WIDTH multiplier. Operands are split into
//   4-bit nibbles (NB = WIDTH/4 per operand); one 4x4 sub-product per clock
//   is accumulated through a single shared 4x4 multiplier, so a nonzero
//   product takes NB*NB cycles. In approximate mode the TRUNC LSBs of every
//   sub-product except the (0,0) block are zeroed before accumulation.
//   A zero operand short-cuts straight to the result.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   bus        - slave side of approx_rec_mult_seq_if (operand and result
//                valid/ready handshakes, a, b, approx, y)
//   busy       - high while a transaction is in CALC or DONE
//   dbg_state  - current FSM state (0 IDLE, 1 CALC, 2 DONE)
// ----------------------------------------------------------------------------
module approx_rec_mult_seq #(
    parameter int WIDTH = 16,
    parameter int TRUNC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    approx_rec_mult_seq_if.slave      bus,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int NB = WIDTH / 4;
    localparam int NW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = 2 * WIDTH;
    localparam int SW = $clog2(PW);

    // Keeps the upper 8-TRUNC bits of an approximate sub-product.
    localparam logic [7:0] TRUNC_MASK = 8'hFF << TRUNC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_approx;
    // (r_i, r_j) is the block index: idx = r_i*NB + r_j, r_j runs fastest.
    logic [NW-1:0]      r_i;
    logic [NW-1:0]      r_j;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_y;

    logic               w_accept;
    logic               w_zero;
    logic               w_last_j;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_sh;
    logic [WIDTH-1:0]   w_b_sh;
    logic [3:0]         w_nib_a;
    logic [3:0]         w_nib_b;
    logic [7:0]         w_prod;
    logic               w_drop;
    logic [7:0]         w_prod_m;
    logic [SW-1:0]      w_shamt;
    logic [PW-1:0]      w_term;
    logic [PW-1:0]      w_sum;

    // ------------------------------------------------------------------
    // Handshake and status outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.y         = r_y;
    assign busy          = (r_state != S_IDLE);
    assign dbg_state     = r_state;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_zero   = (bus.a == '0) || (bus.b == '0);

    assign w_last_j = (r_j == NW'(NB - 1));
    assign w_last   = w_last_j && (r_i == NW'(NB - 1));

    // ------------------------------------------------------------------
    // Shared 4x4 sub-product datapath
    // ------------------------------------------------------------------
    assign w_a_sh  = r_a >> {r_i, 2'b00};
    assign w_b_sh  = r_b >> {r_j, 2'b00};
    assign w_nib_a = w_a_sh[3:0];
    assign w_nib_b = w_b_sh[3:0];
    assign w_prod  = w_nib_a * w_nib_b;

    // Block (0,0) stays exact so small products keep their low bits.
    assign w_drop   = r_approx && ((r_i != '0) || (r_j != '0));
    assign w_prod_m = w_drop ? (w_prod & TRUNC_MASK) : w_prod;

    // Weight of block (i,j) is 2^(4i+4j); the largest shift is PW-8.
    assign w_shamt = SW'({r_i, 2'b00}) + SW'({r_j, 2'b00});
    assign w_term  = {{(PW-8){1'b0}}, w_prod_m} << w_shamt;
    assign w_sum   = r_acc + w_term;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Back to IDLE first; a new operand set is taken no earlier
                // than the cycle after the result leaves.
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_approx <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_acc    <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_approx <= bus.approx;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_acc    <= '0;
                        if (w_zero) begin
                            r_y <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    if (w_last_j) begin
                        r_j <= '0;
                        r_i <= r_i + NW'(1);
                    end else begin
                        r_j <= r_j + NW'(1);
                    end
                    if (w_last) begin
                        r_y <= w_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/approx_rec_mult_seq.md
Name: approx_rec_mult_seq

Overview:
Parametrised, iterative successor to the combinational 8x8 recursive multipliers. It splits WIDTH-bit operands into 4-bit nibbles and accumulates one 4x4 sub-product per clock through a single shared 4x4 multiplier. The mode is selected per transaction: exact, or approximate with truncated higher-order sub-products. It sits between operand producers and a consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand width; must be a multiple of 4 and >= 8 (NB = WIDTH/4 nibbles per operand).
TRUNC, 2, number of LSBs zeroed in each approximate sub-product; range 0..7.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
approx  input  1  1 = approximate mode, 0 = exact; sampled with the operands
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  2*WIDTH  product, unsigned
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: rst_n low at a clock edge gives state=IDLE, y=0, out_valid=0, in_ready=1, busy=0, and clears the accumulator and index. Reset mid-CALC or mid-DONE aborts the operation, and the partial result is discarded.
- FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready, latch a, b and approx; clear the accumulator; set idx=0.
  - If a==0 or b==0, go to DONE with y=0. The result is then available 1 cycle after acceptance.
  - Otherwise go to CALC.
- CALC:
  - Each cycle, compute the block for idx, with i = idx / NB (a nibble) and j = idx % NB (b nibble).
  - p = a[4i+3:4i] * b[4j+3:4j] (8 bits, exact).
  - If approx==1 and (i,j) != (0,0), p[TRUNC-1:0] is forced to 0. Block (0,0) is always exact.
  - acc += p << 4*(i+j). acc is 2*WIDTH bits and never overflows.
  - idx increments. After the add for idx==NB*NB-1, load y from the final acc and go to DONE.
- Latency: out_valid rises exactly NB*NB cycles after the accepting edge (4 for WIDTH=8, 16 for WIDTH=16).
- DONE:
  - y is held stable while out_valid && !out_ready.
  - On out_ready, return to IDLE. in_ready rises on the following cycle; there is no same-cycle re-accept.
  - y keeps its last value in IDLE.
- In exact mode, y == a*b for all inputs.
- In approximate mode, y <= a*b, and y == a*b when TRUNC==0.
- Inputs a, b and approx are ignored whenever in_ready==0. Changing them mid-CALC has no effect.
- in_valid held high in DONE does not start a new transaction until IDLE is reached.
- out_ready asserted while not in DONE is ignored.

Test Plan:
- WIDTH=8, TRUNC=2, exact, a=8'hFF, b=8'hFF → out_valid 4 cycles after accept, y=16'd65025.
- WIDTH=8, TRUNC=2, approx, a=8'hFF, b=8'hFF → y=16'd64737. Also a=8'h12, b=8'h34 → approx y=16'd136, exact y=16'd936.
- WIDTH=8, a=0, b=8'h5A, either mode → out_valid 1 cycle after accept, y=0. The next transaction proceeds normally.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → y and out_valid stable, in_ready=0. Change a and b during CALC → result uses the latched operands.
- Assert rst_n=0 at CALC cycle 2 of 4 → next cycle y=0, out_valid=0, in_ready=1. A fresh a=8'h0F, b=8'h0F exact then yields y=16'd225.
- WIDTH=16, random 1000 operand pairs with random mode and random out_ready → exact results match a*b. Approx results match a reference model of the block rule, and all latencies are 16 cycles.
